// File: rtl/pack_metadata_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : pack_metadata_mc_if
// Brief    : Sample/metadata bus between the formatter, the packer and RX FIFO.
// Revision : 1.0  initial release
// ============================================================================
interface pack_metadata_mc_if #(
    parameter int DATA_WIDTH = 16,
    parameter int META_WIDTH = 448,
    parameter int CHAN_W     = 1
) ();
    logic                  enable;
    logic                  init;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  strobe_in;
    logic [META_WIDTH-1:0] meta_data;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  strobe_out;
    logic [CHAN_W-1:0]     chan_out;
    logic                  meta_active;
    logic                  meta_done;

    modport master (
        output enable, init, data_in, strobe_in, meta_data,
        input  data_out, strobe_out, chan_out, meta_active, meta_done
    );

    modport slave (
        input  enable, init, data_in, strobe_in, meta_data,
        output data_out, strobe_out, chan_out, meta_active, meta_done
    );
endinterface
`default_nettype wire

// File: rtl/pack_metadata_mc.sv
`default_nettype none
// ============================================================================
// Module   : pack_metadata_mc
// Brief    : Spreads a per-frame metadata word into the spare high bits of a
//            channel-interleaved sample stream, then fills with zero/sign.
// Revision : 1.0  initial release
// ============================================================================
module pack_metadata_mc #(
    parameter int DATA_WIDTH    = 16,
    parameter int DATA_USED     = 12,
    parameter int META_WIDTH    = 448,
    parameter int NCHAN         = 2,
    parameter int META_ALL_CHAN = 1,
    parameter int FILL_MODE     = 0
) (
    input  logic               clock,
    input  logic               reset,
    pack_metadata_mc_if.slave  bus
);
    localparam int C_PACK_W = DATA_WIDTH - DATA_USED;
    localparam int C_NSLOTS = (META_WIDTH + C_PACK_W - 1) / C_PACK_W;
    localparam int C_HOLD_W = C_NSLOTS * C_PACK_W;
    localparam int C_SLOT_W = $clog2(C_NSLOTS + 1);
    localparam int C_CHAN_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    localparam logic [C_SLOT_W-1:0] C_LAST_SLOT = C_SLOT_W'(C_NSLOTS - 1);
    localparam logic [C_CHAN_W-1:0] C_LAST_CHAN = C_CHAN_W'(NCHAN - 1);

    logic [C_HOLD_W-1:0]   r_hold;
    logic [C_SLOT_W-1:0]   r_slot;
    logic [C_CHAN_W-1:0]   r_chan;
    logic                  r_active;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_strobe_out;
    logic [C_CHAN_W-1:0]   r_chan_out;
    logic                  r_meta_done;

    logic [C_HOLD_W-1:0]   w_hold;
    logic [C_SLOT_W-1:0]   w_slot;
    logic [C_CHAN_W-1:0]   w_chan;
    logic [C_CHAN_W-1:0]   w_chan_next;
    logic                  w_active;
    logic                  w_accept;
    logic                  w_eligible;
    logic                  w_last;
    logic [C_PACK_W-1:0]   w_fill;
    logic [C_PACK_W-1:0]   w_spare;
    logic                  w_unused_hi;

    assign w_unused_hi = ^bus.data_in[DATA_WIDTH-1:DATA_USED];

    generate
        if (FILL_MODE != 0) begin : g_fill_sign
            assign w_fill = {C_PACK_W{bus.data_in[DATA_USED-1]}};
        end else begin : g_fill_zero
            assign w_fill = '0;
        end
    endgenerate

    // A same-cycle init takes effect before the sample is classified, so the
    // sample riding with init becomes channel 0 / slot 0 of the new frame.
    always_comb begin
        w_accept    = bus.enable & bus.strobe_in;
        w_hold      = bus.init ? C_HOLD_W'(bus.meta_data) : r_hold;
        w_slot      = bus.init ? '0 : r_slot;
        w_chan      = bus.init ? '0 : r_chan;
        w_active    = bus.init | r_active;
        w_eligible  = w_accept & w_active & ((META_ALL_CHAN != 0) || (w_chan == '0));
        w_last      = w_eligible & (w_slot == C_LAST_SLOT);
        w_chan_next = (w_chan == C_LAST_CHAN) ? '0 : w_chan + C_CHAN_W'(1);
        w_spare     = w_eligible ? w_hold[C_PACK_W-1:0] : w_fill;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold       <= '0;
            r_slot       <= '0;
            r_chan       <= '0;
            r_active     <= 1'b0;
            r_data_out   <= '0;
            r_strobe_out <= 1'b0;
            r_chan_out   <= '0;
            r_meta_done  <= 1'b0;
        end else begin
            r_hold       <= w_eligible ? (w_hold >> C_PACK_W) : w_hold;
            r_slot       <= w_eligible ? (w_slot + C_SLOT_W'(1)) : w_slot;
            r_active     <= w_active & ~w_last;
            r_chan       <= w_accept ? w_chan_next : w_chan;
            r_strobe_out <= w_accept;
            r_meta_done  <= w_last;
            if (w_accept) begin
                r_data_out <= {w_spare, bus.data_in[DATA_USED-1:0]};
                r_chan_out <= w_chan;
            end
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.strobe_out  = r_strobe_out;
    assign bus.chan_out    = r_chan_out;
    assign bus.meta_active = r_active;
    assign bus.meta_done   = r_meta_done;
endmodule
`default_nettype wire

// File: doc/pack_metadata_mc.md
# pack_metadata_mc

Multi-channel metadata packer for the receive sample path. Latches a metadata word at each frame start (`init`) and spreads it, `PACK_W` bits per sample, into the unused high-order bits of a channel-interleaved sample stream. Sits between the decimation/formatting stage and the RX FIFO. Once the metadata is exhausted, it fills the spare bits with zeros or sign extension.

## Interface
- `DATA_WIDTH`, 16, width of the sample word in and out.
- `DATA_USED`, 12, significant low bits of each sample. Must satisfy 1 ≤ `DATA_USED` < `DATA_WIDTH`.
- `META_WIDTH`, 448, metadata bits latched per frame.
- `NCHAN`, 2, channels interleaved on the stream, in order 0..`NCHAN`-1. Must be ≥ 1.
- `META_ALL_CHAN`, 1. 1 = metadata goes into every sample. 0 = metadata goes only into channel-0 samples; other channels get fill.
- `FILL_MODE`, 0. 0 = spare bits zero. 1 = spare bits copy `data_in[DATA_USED-1]` (sign extension).

- `clock` in 1: clock. All logic acts on the rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `enable` in 1: when low, strobes are ignored (no output, counters hold). `init` still acts.
- `init` in 1: frame start. Latches `meta_data`, clears the slot and channel counters.
- `data_in` in `DATA_WIDTH`: input sample.
- `strobe_in` in 1: `data_in` valid this cycle.
- `meta_data` in `META_WIDTH`: metadata, sampled only when `init` is high.
- `data_out` out `DATA_WIDTH`: packed sample.
- `strobe_out` out 1: one-cycle valid pulse for `data_out`.
- `chan_out` out ceil(log2(`NCHAN`)), min 1: channel index of `data_out`.
- `meta_active` out 1: high while metadata slots remain to be emitted.
- `meta_done` out 1: pulses together with the `strobe_out` that carries the final slot.

## Operation
- Derived values:
  - `PACK_W` = `DATA_WIDTH` − `DATA_USED`.
  - `NSLOTS` = ceil(`META_WIDTH`/`PACK_W`).
  - Bits of the last slot beyond `META_WIDTH` are zero.
- State:
  - hold shift register, `NSLOTS`·`PACK_W` bits.
  - slot counter, 0..`NSLOTS`.
  - channel counter, 0..`NCHAN`-1.
  - `meta_active` flag.
- `init` high: hold ← zero-extended `meta_data`, slot counter ← 0, channel counter ← 0, `meta_active` ← 1. Any unfinished previous frame is abandoned silently.
- Accepted sample: `enable & strobe_in`. Channel c = channel counter, or 0 if `init` is high in the same cycle.
- Eligible sample: `meta_active` (after the same-cycle `init` update) and (`META_ALL_CHAN` or c == 0). For an eligible sample:
  - `data_out` = {hold[`PACK_W`-1:0], `data_in`[`DATA_USED`-1:0]}.
  - hold shifts right by `PACK_W`.
  - slot counter increments.
  - on reaching `NSLOTS`: `meta_active` ← 0 and `meta_done` = 1.
- Non-eligible sample: `data_out` = {fill, `data_in`[`DATA_USED`-1:0]}, with fill set by `FILL_MODE`.
- Every accepted sample:
  - `chan_out` ← c.
  - channel counter ← (c+1) mod `NCHAN`.
- `init` together with `strobe_in`: the sample is accepted as channel 0 of the new frame and carries slot 0 of the new metadata. It is not dropped.
- `meta_data` is ignored except when `init` is high. Changing it mid-frame has no effect.

## Timing
- Latency is 1 clock: output registers update on the edge that samples `strobe_in`.
- `strobe_out` and `meta_done` are single-cycle pulses. Back-to-back strobes give back-to-back outputs with no gaps.
- Reset values: `data_out` = 0, `strobe_out` = 0, `chan_out` = 0, `meta_active` = 0, `meta_done` = 0. Hold and both counters also clear.
- Reset overrides `init` and `strobe_in` in the same cycle. Reset mid-frame discards the frame.
- After reset, before any `init`: every sample gets fill, and `meta_active` stays 0.
- `data_out` and `chan_out` hold their values between strobes.

## Test plan
- **Defaults, single frame.** `init` with `meta_data` = 448'h0123…CDEF, then 120 strobes alternating ch0/ch1, each with `data_in` = 16'hFABC.
  - Output k carries nibble k of the metadata over 12'hABC.
  - `meta_done` pulses with output 111.
  - Outputs 112+ are 16'h0ABC, and `chan_out` alternates 0/1.
- **`META_ALL_CHAN`=0, `NCHAN`=4.** Slots appear only where `chan_out`=0; channels 1–3 get fill.
  - `meta_done` pulses with the 112th channel-0 sample, which is overall sample 445.
- **`FILL_MODE`=1, `META_WIDTH`=10, `PACK_W`=4.** `NSLOTS`=3; the third slot's top 2 bits are zero.
  - Later sample 12'h800 → 16'hF800; sample 12'h7FF → 16'h07FF.
- **Frame boundary.** Second `init` coincident with `strobe_in` after 50 samples.
  - That sample shows slot 0 of the new metadata, `chan_out`=0.
  - The old frame produces no `meta_done`.
- **Enable and reset.** With `enable`=0, strobes produce no `strobe_out` and counters hold.
  - Reset asserted mid-frame → all outputs 0 next cycle, `meta_active`=0.
  - Subsequent samples get fill until the next `init`.
